// File: rtl/count_updown_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_updown_checker
// Brief    : Step monitor for a paired up/down counter (count_a up, count_b
//            down). Hunts for LOCK_N good steps, then flags and counts errors.
//            Define CHECK_SUM_EN to also require count_a + count_b == all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module count_updown_checker #(
  parameter int W      = 4,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [W-1:0]     count_a,
  input  logic [W-1:0]     count_b,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam int BW = (LOSS_N < 1) ? 1 : $clog2(LOSS_N + 1);
  localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_N - 1);
  localparam logic [BW-1:0]    LOSS_LAST = BW'(LOSS_N - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  prev_a;
  logic [W-1:0]  prev_b;
  logic          have_prev;
  logic [GW-1:0] good_run;
  logic [BW-1:0] bad_run;

  logic step_match;
  logic sum_ok;
  logic step_ok;

  assign step_match = (count_a == prev_a + W'(1)) && (count_b == prev_b - W'(1));

`ifdef CHECK_SUM_EN
  // Counters reset together, so a legal pair is always bitwise complementary.
  assign sum_ok = ((count_a + count_b) == {W{1'b1}});
`else
  assign sum_ok = 1'b1;
`endif

  assign step_ok = step_match && sum_ok;
  assign locked  = (state == LOCK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      prev_a    <= '0;
      prev_b    <= '0;
      have_prev <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (sample_en) begin
        if (!have_prev) begin
          // First usable sample only seeds the reference; no step judged yet.
          if (sum_ok) begin
            prev_a    <= count_a;
            prev_b    <= count_b;
            have_prev <= 1'b1;
          end
        end else begin
          prev_a <= count_a;
          prev_b <= count_b;
          case (state)
            HUNT: begin
              if (step_ok) begin
                if (good_run == LOCK_LAST) begin
                  state    <= LOCK;
                  good_run <= '0;
                end else begin
                  good_run <= good_run + GW'(1);
                end
              end else begin
                good_run <= '0;
              end
            end
            LOCK: begin
              if (step_ok) begin
                bad_run <= '0;
              end else begin
                err_pulse <= 1'b1;
                if (err_cnt != ERR_MAX) begin
                  err_cnt <= err_cnt + ERR_W'(1);
                end
                if (bad_run == LOSS_LAST) begin
                  state    <= HUNT;
                  bad_run  <= '0;
                  good_run <= '0;
                end else begin
                  bad_run <= bad_run + BW'(1);
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
      // Clear takes priority over any increment made this cycle.
      if (err_clr) begin
        err_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_updown_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_updown_checker
// Brief    : Directed and randomized check of count_updown_checker against a
//            step-rule model of the monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_updown_checker;

  localparam int W       = 4;
  localparam int MOD     = 16;
  localparam int LOCK_N  = 4;
  localparam int LOSS_N  = 3;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic [W-1:0]     count_a;
  logic [W-1:0]     count_b;
  logic             err_clr;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  count_updown_checker #(
    .W      (W),
    .LOCK_N (LOCK_N),
    .LOSS_N (LOSS_N),
    .ERR_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .count_a   (count_a),
    .count_b   (count_b),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  // Model: what the outputs must be, derived from the step rules.
  bit m_locked, m_pulse, m_have;
  int m_pa, m_pb, m_good, m_bad, m_err;

  function automatic void model_reset();
    m_locked = 0; m_pulse = 0; m_have = 0;
    m_pa = 0; m_pb = 0; m_good = 0; m_bad = 0; m_err = 0;
  endfunction

  function automatic void model_clock(bit en, int a, int b, bit clr);
    bit sum_ok;
    bit ok;
    m_pulse = 0;
    if (en) begin
`ifdef CHECK_SUM_EN
      sum_ok = ((a + b) % MOD) == (MOD - 1);
`else
      sum_ok = 1;
`endif
      if (!m_have) begin
        if (sum_ok) begin
          m_pa = a; m_pb = b; m_have = 1;
        end
      end else begin
        ok = (a == (m_pa + 1) % MOD) && (b == (m_pb + MOD - 1) % MOD) && sum_ok;
        m_pa = a; m_pb = b;
        if (!m_locked) begin
          if (ok) begin
            m_good++;
            if (m_good == LOCK_N) begin m_locked = 1; m_good = 0; end
          end else m_good = 0;
        end else begin
          if (ok) m_bad = 0;
          else begin
            m_pulse = 1;
            if (m_err < ERR_MAX) m_err++;
            m_bad++;
            if (m_bad == LOSS_N) begin m_locked = 0; m_bad = 0; m_good = 0; end
          end
        end
      end
    end
    if (clr) m_err = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("locked", {31'd0, locked}, {31'd0, m_locked});
      check("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
      check("err_cnt", {30'd0, err_cnt}, m_err);
    end
  end

  int ca, cb;

  task automatic step(input bit en, input int a, input int b, input bit clr);
    sample_en = en;
    count_a   = W'(a);
    count_b   = W'(b);
    err_clr   = clr;
    @(posedge clk);
    model_clock(en, a % MOD, b % MOD, clr);
    #1;
  endtask

  task automatic good(input bit clr);
    ca = (ca + 1) % MOD;
    cb = (cb + MOD - 1) % MOD;
    step(1, ca, cb, clr);
  endtask

  // Both counters skip a value: an illegal step that keeps the pair complementary.
  task automatic bad(input bit clr);
    ca = (ca + 2) % MOD;
    cb = (cb + MOD - 2) % MOD;
    step(1, ca, cb, clr);
  endtask

  initial begin
    rst = 1'b0; sample_en = 1'b0; count_a = '0; count_b = '0; err_clr = 1'b0;
    model_reset();
    chk_on = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_err_cnt", {30'd0, err_cnt}, 0);
    rst = 1'b1;

    // Startup: first sample seeds, four good steps lock.
    ca = 0; cb = MOD - 1;
    step(1, ca, cb, 0);
    repeat (3) good(0);
    check("lock_early", {31'd0, locked}, 0);
    good(0);
    check("lock_5th", {31'd0, locked}, 1);
    check("lock_err_cnt", {30'd0, err_cnt}, 0);

    // Wrap through F->0 / 0->F is legal.
    while (ca != 13) good(0);
    repeat (4) begin
      good(0);
      check("wrap_pulse", {31'd0, err_pulse}, 0);
    end
    check("wrap_locked", {31'd0, locked}, 1);

    // Single error in LOCK.
    bad(0);
    check("err1_pulse", {31'd0, err_pulse}, 1);
    check("err1_cnt", {30'd0, err_cnt}, 1);
    check("err1_locked", {31'd0, locked}, 1);
    good(0);
    check("err1_pulse_end", {31'd0, err_pulse}, 0);

    // Clear, then three bad steps drop lock; four good steps relock.
    good(1);
    check("clr_cnt", {30'd0, err_cnt}, 0);
    repeat (3) bad(0);
    check("loss_locked", {31'd0, locked}, 0);
    check("loss_cnt", {30'd0, err_cnt}, 3);
    repeat (4) good(0);
    check("relock", {31'd0, locked}, 1);

    // Saturation and clear-wins.
    bad(0);
    check("sat_cnt", {30'd0, err_cnt}, 3);
    bad(1);
    check("clrwin_cnt", {30'd0, err_cnt}, 0);
    check("clrwin_pulse", {31'd0, err_pulse}, 1);
    good(0);
    check("still_locked", {31'd0, locked}, 1);
    bad(0);
    check("pre_rst_cnt", {30'd0, err_cnt}, 1);

    // Asynchronous reset mid-cycle.
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_locked", {31'd0, locked}, 0);
    check("async_cnt", {30'd0, err_cnt}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic.
    ca = $urandom_range(0, MOD - 1);
    cb = MOD - 1 - ca;
    for (int i = 0; i < 3000; i++) begin
      int k;
      bit clr;
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      if ($urandom_range(0, 99) < 75) begin
        k = $urandom_range(0, 99);
        if (k < 88) begin
          ca = (ca + 1) % MOD; cb = (cb + MOD - 1) % MOD;
        end else if (k < 93) begin
          ca = (ca + 2) % MOD; cb = (cb + MOD - 2) % MOD;
        end else if (k < 96) begin
          ca = $urandom_range(0, MOD - 1); cb = (cb + MOD - 1) % MOD;
        end else begin
          ca = $urandom_range(0, MOD - 1); cb = MOD - 1 - ca;
        end
        step(1, ca, cb, clr);
      end else begin
        step(0, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), clr);
      end
    end

    @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
